// File: rtl/sram_word_packer_if.sv
// Handshake and SRAM write-port bundle for the word packer.
// The DUT takes the slave view; the stream/controller side takes the master view.
interface sram_word_packer_if #(
  parameter int ELEM_W = 11,
  parameter int LANES  = 9,
  parameter int ADDR_W = 11
);
  localparam int WORD_W = ELEM_W * LANES;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_cnt;
  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_waddr;
  logic [WORD_W-1:0] sram_wdata;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, word_cnt, in_valid, in_data,
    output in_ready, sram_csb, sram_wsb, sram_waddr, sram_wdata, busy, done
  );

  modport master (
    output start, base_addr, word_cnt, in_valid, in_data,
    input  in_ready, sram_csb, sram_wsb, sram_waddr, sram_wdata, busy, done
  );
endinterface

// File: rtl/sram_word_packer.sv
// Packs LANES consecutive stream elements into one SRAM word and writes the
// words at consecutive addresses starting from a base, wrapping at DEPTH.
module sram_word_packer #(
  parameter int ELEM_W = 11,
  parameter int LANES  = 9,
  parameter int DEPTH  = 1728,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  sram_word_packer_if.slave   bus
);
  localparam int WORD_W = ELEM_W * LANES;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_base, w_base_next;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
  logic [ADDR_W-1:0]   r_word_idx, w_word_idx_next;
  logic [LANE_W-1:0]   r_lane, w_lane_next;
  logic [ELEM_W-1:0]   r_lane_data [LANES-1];
  logic                r_csb, w_csb_next;
  logic                r_wsb, w_wsb_next;
  logic [ADDR_W-1:0]   r_waddr, w_waddr_next;
  logic [WORD_W-1:0]   r_wdata, w_wdata_next;
  logic                r_in_ready, w_in_ready_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;

  logic                w_accept;
  logic                w_last_lane;
  logic                w_last_word;
  logic [ADDR_W:0]     w_addr_sum;
  logic [ADDR_W:0]     w_addr_wrapped;
  logic [WORD_W-1:0]   w_word;

  assign w_accept    = (r_state == FILL) && bus.in_valid && r_in_ready;
  assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
  assign w_last_word = ({1'b0, r_word_idx} + (ADDR_W+1)'(1)) == {1'b0, r_cnt};

  // base < DEPTH and word_idx < DEPTH, so a single conditional subtract suffices.
  assign w_addr_sum     = {1'b0, r_base} + {1'b0, r_word_idx};
  assign w_addr_wrapped = (w_addr_sum >= (ADDR_W+1)'(DEPTH)) ?
                          (w_addr_sum - (ADDR_W+1)'(DEPTH)) : w_addr_sum;

  // The last lane bypasses storage and goes straight from the input into the word.
  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (w_accept && (r_lane == LANE_W'(gi))) begin
          r_lane_data[gi] <= bus.in_data;
        end
      end
      assign w_word[gi*ELEM_W +: ELEM_W] = r_lane_data[gi];
    end
  endgenerate
  assign w_word[WORD_W-1 -: ELEM_W] = bus.in_data;

  always_comb begin
    w_state_next    = r_state;
    w_base_next     = r_base;
    w_cnt_next      = r_cnt;
    w_word_idx_next = r_word_idx;
    w_lane_next     = r_lane;
    w_csb_next      = 1'b1;
    w_wsb_next      = 1'b1;
    w_waddr_next    = r_waddr;
    w_wdata_next    = r_wdata;
    w_in_ready_next = 1'b0;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_base_next     = bus.base_addr;
          w_cnt_next      = bus.word_cnt;
          w_word_idx_next = '0;
          w_lane_next     = '0;
          w_busy_next     = 1'b1;
          if (bus.word_cnt == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next    = FILL;
            w_in_ready_next = 1'b1;
          end
        end
      end
      FILL: begin
        w_busy_next     = 1'b1;
        w_in_ready_next = 1'b1;
        if (w_accept) begin
          if (w_last_lane) begin
            w_lane_next     = '0;
            w_word_idx_next = r_word_idx + ADDR_W'(1);
            w_csb_next      = 1'b0;
            w_wsb_next      = 1'b0;
            w_waddr_next    = w_addr_wrapped[ADDR_W-1:0];
            w_wdata_next    = w_word;
            if (w_last_word) begin
              w_state_next    = DONE;
              w_in_ready_next = 1'b0;
            end
          end else begin
            w_lane_next = r_lane + LANE_W'(1);
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
        w_done_next  = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_cnt      <= '0;
      r_word_idx <= '0;
      r_lane     <= '0;
      r_csb      <= 1'b1;
      r_wsb      <= 1'b1;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_base     <= w_base_next;
      r_cnt      <= w_cnt_next;
      r_word_idx <= w_word_idx_next;
      r_lane     <= w_lane_next;
      r_csb      <= w_csb_next;
      r_wsb      <= w_wsb_next;
      r_waddr    <= w_waddr_next;
      r_wdata    <= w_wdata_next;
      r_in_ready <= w_in_ready_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.sram_csb   = r_csb;
  assign bus.sram_wsb   = r_wsb;
  assign bus.sram_waddr = r_waddr;
  assign bus.sram_wdata = r_wdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_sram_word_packer.sv
// Scoreboard bench: the driver pushes expected SRAM writes and per-transfer
// write counts; a negedge monitor pops and compares whatever the DUT emits.
module tb_sram_word_packer;
  localparam int DEPTH = 1728;

  typedef struct {
    logic [10:0] addr;
    logic [98:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_word_packer_if intf ();

  sram_word_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  wr_t exp_q[$];
  int  done_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  int  n_done = 0;
  int  cyc    = 0;
  int  strobes_since   = 0;
  int  last_strobe_cyc = -10;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every SRAM write and every done pulse against the queues.
  always @(negedge clk) begin
    cyc++;
    if (!intf.sram_csb || !intf.sram_wsb) begin
      check("csb_eq_wsb", {127'b0, intf.sram_csb}, {127'b0, intf.sram_wsb});
      if (exp_q.size() == 0) begin
        check("unexpected_write", 128'd1, 128'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", {117'b0, intf.sram_waddr}, {117'b0, e.addr});
        check("wdata", {29'b0, intf.sram_wdata}, {29'b0, e.data});
      end
      strobes_since++;
      last_strobe_cyc = cyc;
    end
    if (intf.in_ready && !intf.busy) check("ready_implies_busy", 128'd0, 128'd1);
    if (intf.done) begin
      check("done_single_cycle", {127'b0, prev_done}, 128'd0);
      check("busy_low_at_done", {127'b0, intf.busy}, 128'd0);
      if (done_q.size() == 0) begin
        check("unexpected_done", 128'd1, 128'd0);
      end else begin
        int exp_n;
        exp_n = done_q.pop_front();
        check("writes_per_transfer", 128'(strobes_since), 128'(exp_n));
        if (exp_n > 0) check("done_after_last_write", 128'(last_strobe_cyc), 128'(cyc - 1));
      end
      strobes_since = 0;
      n_done++;
    end
    prev_done = intf.done;
  end

  // Called at a negedge; returns at the negedge after the element was taken.
  task automatic send_elem(input logic [10:0] d);
    int waited = 0;
    intf.in_valid = 1'b1;
    intf.in_data  = d;
    while (!intf.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!intf.in_ready) check("accept_timeout", 128'd0, 128'd1);
    @(negedge clk);
  endtask

  // stall: 0 none, 1 one idle cycle between elements, 2 random idles.
  task automatic run_transfer(input int base, input int cnt, input bit seq,
                              input int stall, input bit start_mid);
    logic [10:0] elems[$];
    int target;
    int guard;
    for (int i = 0; i < cnt * 9; i++) begin
      elems.push_back(seq ? 11'(i + 1) : 11'($urandom_range(0, 2047)));
    end
    for (int w = 0; w < cnt; w++) begin
      wr_t e;
      e.addr = 11'((base + w) % DEPTH);
      e.data = '0;
      for (int l = 0; l < 9; l++) e.data = e.data | (99'(elems[w*9 + l]) << (11 * l));
      exp_q.push_back(e);
    end
    done_q.push_back(cnt);
    target = n_done + 1;
    intf.start     = 1'b1;
    intf.base_addr = 11'(base);
    intf.word_cnt  = 11'(cnt);
    @(negedge clk);
    intf.start = 1'b0;
    for (int i = 0; i < elems.size(); i++) begin
      if ((stall == 1 && i > 0) || (stall == 2 && $urandom_range(0, 3) == 0)) begin
        intf.in_valid = 1'b0;
        intf.in_data  = 11'($urandom_range(0, 2047));
        @(negedge clk);
      end
      if (start_mid && i == 4) begin
        intf.start     = 1'b1;
        intf.base_addr = 11'd500;
        intf.word_cnt  = 11'd5;
      end
      send_elem(elems[i]);
      intf.start = 1'b0;
    end
    intf.in_valid = 1'b0;
    guard = 0;
    while (n_done < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (n_done < target) check("done_timeout", 128'd0, 128'd1);
    @(negedge clk);
    $display("transfer base=%0d cnt=%0d stall=%0d start_mid=%0d finished at cycle %0d",
             base, cnt, stall, start_mid, cyc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_csb"},      {127'b0, intf.sram_csb}, 128'd1);
    check({tag, "_wsb"},      {127'b0, intf.sram_wsb}, 128'd1);
    check({tag, "_in_ready"}, {127'b0, intf.in_ready}, 128'd0);
    check({tag, "_busy"},     {127'b0, intf.busy},     128'd0);
    check({tag, "_done"},     {127'b0, intf.done},     128'd0);
  endtask

  initial begin
    intf.start     = 1'b0;
    intf.base_addr = '0;
    intf.word_cnt  = '0;
    intf.in_valid  = 1'b0;
    intf.in_data   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_waddr", {117'b0, intf.sram_waddr}, 128'd0);
    check("reset_wdata", {29'b0, intf.sram_wdata}, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle_outputs("idle");
    end

    run_transfer(0, 2, 1'b1, 0, 1'b0);
    run_transfer(1726, 3, 1'b0, 0, 1'b0);
    run_transfer(37, 1, 1'b0, 1, 1'b0);
    run_transfer(0, 0, 1'b0, 0, 1'b0);
    run_transfer(100, 2, 1'b0, 0, 1'b1);

    // Abort a partial word with reset; nothing may be written for it.
    intf.start     = 1'b1;
    intf.base_addr = 11'd5;
    intf.word_cnt  = 11'd1;
    @(negedge clk);
    intf.start = 1'b0;
    for (int i = 0; i < 5; i++) send_elem(11'($urandom_range(0, 2047)));
    intf.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    check("midreset_waddr", {117'b0, intf.sram_waddr}, 128'd0);
    check("midreset_wdata", {29'b0, intf.sram_wdata}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    run_transfer(9, 1, 1'b1, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      run_transfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), 1'b0, 2, 1'b0);
    end
    run_transfer(1000, DEPTH, 1'b0, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("writes_left_over", 128'(exp_q.size()), 128'd0);
    check("dones_left_over", 128'(done_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_word_packer.md
# sram_word_packer

Write-side front end for the 1728x99-bit weight/feature SRAM. It accepts a stream of 11-bit elements over a valid/ready handshake, packs nine consecutive elements into one 99-bit word and issues one SRAM write per word at consecutive addresses. Addresses start from a programmable base and wrap modulo the SRAM depth. The block sits between the off-chip/DMA input stream and the SRAM macro's write port, and signals completion to the top-level controller.

## Interface
- ELEM_W, 11, element width in bits
- LANES, 9, elements per SRAM word (word width = ELEM_W*LANES = 99)
- DEPTH, 1728, SRAM depth in words; address wrap point
- ADDR_W, 11, SRAM address width

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a transfer; ignored while busy=1
- base_addr  in  ADDR_W  first write address, sampled on start; must be < DEPTH
- word_cnt  in  ADDR_W  number of words to write, sampled on start; legal range 0..DEPTH
- in_valid  in  1  input element valid
- in_data  in  ELEM_W  input element
- in_ready  out  1  block can accept an element this cycle
- sram_csb  out  1  SRAM chip enable, active low
- sram_wsb  out  1  SRAM write enable, active low
- sram_waddr  out  ADDR_W  SRAM write address
- sram_wdata  out  99  SRAM write data
- busy  out  1  transfer in progress
- done  out  1  single-cycle pulse at end of transfer

## Operation
- States: IDLE, FILL, DONE.
- IDLE: in_ready=0, busy=0. On start: latch base_addr and word_cnt, clear lane and word counters. If word_cnt=0, go to DONE without any write; otherwise go to FILL.
- FILL: in_ready=1, busy=1. An element is accepted on a posedge where in_valid=1 and in_ready=1. Element at lane index i occupies bits [11i+10:11i]; lane 0 is the LSBs.
- On acceptance of lane 8:
  - the completed word goes onto sram_wdata, with sram_waddr = (base + word_idx) mod DEPTH;
  - sram_csb=0 and sram_wsb=0 for exactly one cycle;
  - the lane counter returns to 0 and word_idx increments.
- Acceptance continues back-to-back during the write cycle. Sustained throughput is one element per cycle with no bubbles.
- If the accepted lane 8 completes word word_cnt-1, go to DONE; in_ready is 0 from that edge.
- DONE: busy=1 for one cycle, then go to IDLE with done=1 for exactly that one cycle.
- Address arithmetic: the sum is computed in ADDR_W+1 bits. If the sum is ≥ DEPTH, DEPTH is subtracted; no other wrap exists.
- in_valid=0 in FILL stalls the block indefinitely with no side effects. The write strobe stays inactive.
- start while busy=1 has no effect. The latched parameters do not change mid-transfer.
- Outputs registered: csb, wsb, waddr, wdata, in_ready, busy, done.

## Timing
- Reset values (next posedge with rst=1):
  - state=IDLE
  - sram_csb=1, sram_wsb=1
  - sram_waddr=0, sram_wdata=0
  - in_ready=0, busy=0, done=0
- Reset mid-transfer: a partial word is discarded and no write is issued for it. A strobe already asserted is removed at the reset edge.
- start sampled at edge T: busy=1 and in_ready=1 (if word_cnt≠0) from T.
- Lane 8 accepted at edge k:
  - write strobe is low from k to k+1;
  - the SRAM captures on the negedge inside that cycle, giving half a cycle of setup;
  - waddr and wdata are stable across that negedge.
- Final word's lane 8 at edge k:
  - write strobe k..k+1;
  - DONE k..k+1;
  - done=1 and busy=0 from k+1 to k+2.
- word_cnt=0 with start at T: done=1 from T+1 to T+2. No strobe is issued.
- Minimum transfer of N words with continuous in_valid: 9N cycles from start to the last strobe, plus one cycle to done.

## Test plan
- Reset, then idle 10 cycles -> csb=wsb=1, in_ready=0, busy=0, done=0 throughout.
- start, base=0, cnt=2; elements 1..18 continuous -> two strobes: addr 0 with lanes 1..9 (bits[10:0]=1, bits[98:88]=9), then addr 1 with lanes 10..18. done occurs one cycle after the second strobe.
- base=1726, cnt=3, random data -> strobes at addresses 1726, 1727, 0; data matches a packing model.
- cnt=1 with in_valid toggling 1-0-1 every cycle -> exactly one strobe after the 9th accepted element. No strobe appears on stall cycles; elements are not duplicated or dropped.
- cnt=0 -> no strobe; done pulses for one cycle; a start issued during an active cnt=2 transfer is ignored (only 2 strobes occur).
- rst asserted after 5 elements of word 0 -> next edge has all outputs at reset values. A new start with cnt=1 then packs only the new 9 elements.
